// File: rtl/nes_joypad_port.sv
// ---------------------------------------------------------------------------
// nes_joypad_port
//
// Purpose: CPU-bus responder for the two NES controller ports. A write to
// BASE_ADDR sets the strobe latch. While strobe is high both shift registers
// follow the live buttons. Once strobe drops, each read of a port returns the
// next button bit, starting with A, and shifts in a 1 behind it.
//
// Ports:
//   clk          block clock, shared with the memory model
//   reset        synchronous reset, active-high
//   cycle_valid  CPU bus cycle valid; an access is taken on its rising edge
//   addr[15:0]   CPU address bus
//   r_w_n        1 = read, 0 = write
//   din[7:0]     write data from the CPU
//   dout[7:0]    registered read data toward the CPU
//   dout_en      one-clock request for the top level to drive D with dout
//   btn_p1[7:0]  live port 1 buttons, 1 = pressed, bit 0 = A ... bit 7 = Right
//   btn_p2[7:0]  live port 2 buttons, same bit order
// ---------------------------------------------------------------------------
module nes_joypad_port #(
    parameter logic [15:0] BASE_ADDR = 16'h4016,
    parameter logic [6:0]  OPEN_BUS  = 7'h20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cycle_valid,
    input  logic [15:0] addr,
    input  logic        r_w_n,
    input  logic [7:0]  din,
    output logic [7:0]  dout,
    output logic        dout_en,
    input  logic [7:0]  btn_p1,
    input  logic [7:0]  btn_p2
);

    logic       strobe_q, strobe_d;
    logic [7:0] sr1_q, sr1_d;
    logic [7:0] sr2_q, sr2_d;
    logic       cv_q;
    logic [7:0] dout_q, dout_d;
    logic       dout_en_q, dout_en_d;

    logic access;
    logic hit1, hit2;
    logic wr1, rd1, rd2;
    logic reload;

    assign access = cycle_valid & ~cv_q;
    assign hit1   = (addr == BASE_ADDR);
    assign hit2   = (addr == BASE_ADDR + 16'd1);

    // Writes to the second address belong to the APU frame counter and are
    // deliberately not decoded here.
    assign wr1 = access & ~r_w_n & hit1;
    assign rd1 = access &  r_w_n & hit1;
    assign rd2 = access &  r_w_n & hit2;

    always_comb begin
        strobe_d = strobe_q;
        if (wr1) begin
            strobe_d = din[0];
        end
    end

    // Reloading on either the old or the new strobe value gives the last
    // button capture on the falling strobe edge, and a continuous follow of
    // the buttons while strobe stays high.
    assign reload = strobe_q | strobe_d;

    always_comb begin
        sr1_d = sr1_q;
        sr2_d = sr2_q;
        if (reload) begin
            sr1_d = btn_p1;
            sr2_d = btn_p2;
        end else begin
            if (rd1) begin
                sr1_d = {1'b1, sr1_q[7:1]};
            end
            if (rd2) begin
                sr2_d = {1'b1, sr2_q[7:1]};
            end
        end
    end

    // Read data comes from the register value before this edge, so a read
    // with strobe high returns the previously captured A bit.
    always_comb begin
        dout_d    = dout_q;
        dout_en_d = 1'b0;
        if (rd1) begin
            dout_d    = {OPEN_BUS, sr1_q[0]};
            dout_en_d = 1'b1;
        end else if (rd2) begin
            dout_d    = {OPEN_BUS, sr2_q[0]};
            dout_en_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            strobe_q  <= 1'b0;
            sr1_q     <= 8'hFF;
            sr2_q     <= 8'hFF;
            cv_q      <= 1'b0;
            dout_q    <= 8'h00;
            dout_en_q <= 1'b0;
        end else begin
            strobe_q  <= strobe_d;
            sr1_q     <= sr1_d;
            sr2_q     <= sr2_d;
            cv_q      <= cycle_valid;
            dout_q    <= dout_d;
            dout_en_q <= dout_en_d;
        end
    end

    assign dout    = dout_q;
    assign dout_en = dout_en_q;

endmodule

// File: tb/tb_nes_joypad_port.sv
// ---------------------------------------------------------------------------
// tb_nes_joypad_port
//
// Purpose: self-checking bench for nes_joypad_port. Bus tasks push the
// expected read byte into a queue when a read is issued; a monitor pops and
// compares on every dout_en pulse. A pulse with nothing expected is an error.
// ---------------------------------------------------------------------------
module tb_nes_joypad_port;

    logic        clk = 1'b0;
    logic        reset;
    logic        cycle_valid;
    logic [15:0] addr;
    logic        r_w_n;
    logic [7:0]  din;
    logic [7:0]  dout;
    logic        dout_en;
    logic [7:0]  btn_p1;
    logic [7:0]  btn_p2;

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    nes_joypad_port dut (
        .clk         (clk),
        .reset       (reset),
        .cycle_valid (cycle_valid),
        .addr        (addr),
        .r_w_n       (r_w_n),
        .din         (din),
        .dout        (dout),
        .dout_en     (dout_en),
        .btn_p1      (btn_p1),
        .btn_p2      (btn_p2)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    // Monitor: every dout_en pulse must match the oldest expected read.
    initial begin
        forever begin
            @(negedge clk);
            if (dout_en === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_dout_en: got dout=%02h expected no pulse", dout);
                end else begin
                    check("read_data", dout, exp_q.pop_front());
                end
            end
        end
    end

    task automatic bus(input logic [15:0] a, input logic rnw, input logic [7:0] d, input int hold);
        @(negedge clk);
        addr        = a;
        r_w_n       = rnw;
        din         = d;
        cycle_valid = 1'b1;
        repeat (hold) @(posedge clk);
        @(negedge clk);
        cycle_valid = 1'b0;
        @(posedge clk);
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        bus(a, 1'b0, d, 1);
    endtask

    task automatic rd(input logic [15:0] a, input logic bit0);
        exp_q.push_back({7'h20, bit0});
        bus(a, 1'b1, 8'h00, 1);
    endtask

    // Change buttons and let one clock pass so strobe-follow sees them.
    task automatic set_btn(input logic [7:0] b1, input logic [7:0] b2);
        @(negedge clk);
        btn_p1 = b1;
        btn_p2 = b2;
        @(posedge clk);
    endtask

    task automatic strobe_pulse();
        wr(16'h4016, 8'h01);
        wr(16'h4016, 8'h00);
    endtask

    logic [9:0] seq10;

    initial begin
        reset       = 1'b1;
        cycle_valid = 1'b0;
        addr        = 16'h0000;
        r_w_n       = 1'b1;
        din         = 8'h00;
        btn_p1      = 8'h00;
        btn_p2      = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_dout", dout, 8'h00);
        check("reset_dout_en", {7'h0, dout_en}, 8'h00);
        reset = 1'b0;

        // No strobe after reset: registers hold $FF.
        rd(16'h4016, 1'b1);
        rd(16'h4016, 1'b1);

        // Serial readout of 1000_0101, then 1-fill.
        set_btn(8'b1000_0101, 8'h00);
        strobe_pulse();
        seq10 = 10'b11_1000_0101;
        for (int i = 0; i < 10; i++) begin
            rd(16'h4016, seq10[i]);
        end

        // Strobe held high: reads follow the live A bit without shifting.
        wr(16'h4016, 8'h01);
        set_btn(8'h00, 8'h00);
        rd(16'h4016, 1'b0);
        set_btn(8'h01, 8'h00);
        rd(16'h4016, 1'b1);
        set_btn(8'h00, 8'h00);
        rd(16'h4016, 1'b0);
        // Falling strobe captures 03; later button changes are invisible.
        set_btn(8'h03, 8'h00);
        wr(16'h4016, 8'h00);
        set_btn(8'h00, 8'h00);
        rd(16'h4016, 1'b1);
        rd(16'h4016, 1'b1);
        rd(16'h4016, 1'b0);

        // Independent shift registers.
        set_btn(8'hFF, 8'h02);
        strobe_pulse();
        rd(16'h4017, 1'b0);
        rd(16'h4016, 1'b1);
        rd(16'h4017, 1'b1);
        rd(16'h4017, 1'b0);

        // Long cycle_valid counts once; $4017 writes and $4018 reads are inert.
        set_btn(8'b0000_0010, 8'h00);
        strobe_pulse();
        set_btn(8'h00, 8'h00);
        exp_q.push_back(8'h40);
        bus(16'h4016, 1'b1, 8'h00, 5);
        wr(16'h4017, 8'h01);
        bus(16'h4018, 1'b1, 8'h00, 1);
        rd(16'h4016, 1'b1);
        rd(16'h4016, 1'b0);

        // Reset during a read access drops the access and clears state.
        set_btn(8'h00, 8'h00);
        strobe_pulse();
        rd(16'h4016, 1'b0);
        rd(16'h4016, 1'b0);
        rd(16'h4016, 1'b0);
        @(negedge clk);
        addr        = 16'h4016;
        r_w_n       = 1'b1;
        cycle_valid = 1'b1;
        reset       = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cycle_valid = 1'b0;
        reset       = 1'b0;
        check("reset_mid_dout_en", {7'h0, dout_en}, 8'h00);
        @(posedge clk);
        rd(16'h4016, 1'b1);
        rd(16'h4016, 1'b1);

        // cycle_valid held through reset release counts as one access.
        @(negedge clk);
        reset       = 1'b1;
        addr        = 16'h4017;
        r_w_n       = 1'b1;
        cycle_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        exp_q.push_back(8'h41);
        repeat (3) @(posedge clk);
        @(negedge clk);
        cycle_valid = 1'b0;

        repeat (4) @(posedge clk);
        @(negedge clk);
        check("dout_holds", dout, 8'h41);
        check("pending_reads", 8'(exp_q.size()), 8'h00);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
